// File: rtl/clock_pkg.sv
// Shared types and constants for the clock's button front end.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } rpt_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_PERIOD   = 2;

    // Channel order doubles as arbitration priority (lowest index wins).
    localparam int CH_MODE   = 0;
    localparam int CH_TIMER  = 1;
    localparam int CH_ALARM  = 2;
    localparam int CH_HOUR   = 3;
    localparam int CH_MINUTE = 4;
    localparam int CH_AM     = 5;
    localparam int NUM_CHAN  = 6;
    localparam int NUM_CMD   = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, consecutive-difference counter,
// debounced stable level, and same-edge rise/fall strobes.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // rise/fall fire on the edge that updates stable, so the consumer can
    // register a pulse that lines up with the new stable level.
    assign flip = (sync != stable) && (cnt == CNT_LAST);
    assign rise = flip & sync;
    assign fall = flip & ~sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (flip) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the clock's five push-buttons and AM/PM switch into one-hot command pulses.
// Define BUTTON_AUTOREPEAT_EN to enable hold-to-repeat on add_hour / add_minute.
module button_conditioner
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_mode,
    input  logic raw_hour,
    input  logic raw_minute,
    input  logic raw_timer,
    input  logic raw_alarm,
    input  logic raw_am_mode,
    output logic mode_btn,
    output logic add_hour,
    output logic add_minute,
    output logic set_timer_btn,
    output logic set_alarm_btn,
    output logic AM_mode
);

    logic [NUM_CHAN-1:0] raw;
    logic [NUM_CHAN-1:0] stable;
    logic [NUM_CHAN-1:0] rise;
    logic [NUM_CHAN-1:0] fall;
    logic [NUM_CMD-1:0]  req;
    logic [NUM_CMD-1:0]  grant;

    assign raw = {raw_am_mode, raw_minute, raw_hour, raw_alarm, raw_timer, raw_mode};

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .stable(stable[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign req[CH_ALARM:CH_MODE] = rise[CH_ALARM:CH_MODE];

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RPT_W-1:0] RPT_MAX     = '1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    for (genvar a = CH_HOUR; a <= CH_MINUTE; a++) begin : g_rpt
        rpt_state_t       state;
        logic [RPT_W-1:0] cnt;
        logic             rpt_fire;

        assign rpt_fire = ((state == PRESSED) && (cnt == DELAY_LAST)) ||
                          ((state == REPEAT)  && (cnt == PERIOD_LAST));
        // A release on the same edge as a scheduled repeat cancels that repeat.
        assign req[a] = rise[a] | (rpt_fire & ~fall[a]);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (fall[a]) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (rise[a]) state <= PRESSED;
                    end
                    PRESSED: begin
                        if (cnt == DELAY_LAST) begin
                            state <= REPEAT;
                            cnt   <= '0;
                        end else if (cnt != RPT_MAX) begin
                            cnt <= cnt + RPT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (cnt == PERIOD_LAST) begin
                            cnt <= '0;
                        end else if (cnt != RPT_MAX) begin
                            cnt <= cnt + RPT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
`else
    assign req[CH_MINUTE:CH_HOUR] = rise[CH_MINUTE:CH_HOUR];
`endif

    // Fixed-priority pick; losers are dropped while their FSMs keep running.
    always_comb begin
        logic taken;
        grant = '0;
        taken = 1'b0;
        for (int i = 0; i < NUM_CMD; i++) begin
            if (req[i] && !taken) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {add_minute, add_hour, set_alarm_btn, set_timer_btn, mode_btn} <= '0;
        end else begin
            {add_minute, add_hour, set_alarm_btn, set_timer_btn, mode_btn} <= grant;
        end
    end

    assign AM_mode = stable[CH_AM];

    logic unused_sigs;
    assign unused_sigs = &{1'b0, stable[NUM_CMD-1:0], rise[CH_AM], fall};

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized buttons vs a behavioural model.
// Expectations follow BUTTON_AUTOREPEAT_EN the same way the design does.
module tb_button_conditioner;

    localparam int D    = 4;
    localparam int RD   = 8;
    localparam int RP   = 2;
    localparam int NCH  = 6;
    localparam int LOGN = 4096;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_mode = 1'b0, raw_hour = 1'b0, raw_minute = 1'b0;
    logic raw_timer = 1'b0, raw_alarm = 1'b0, raw_am_mode = 1'b0;
    logic mode_btn, add_hour, add_minute, set_timer_btn, set_alarm_btn, AM_mode;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_mode     (raw_mode),
        .raw_hour     (raw_hour),
        .raw_minute   (raw_minute),
        .raw_timer    (raw_timer),
        .raw_alarm    (raw_alarm),
        .raw_am_mode  (raw_am_mode),
        .mode_btn     (mode_btn),
        .add_hour     (add_hour),
        .add_minute   (add_minute),
        .set_timer_btn(set_timer_btn),
        .set_alarm_btn(set_alarm_btn),
        .AM_mode      (AM_mode)
    );

    // Bit i = channel i: 0 mode, 1 timer, 2 alarm, 3 hour, 4 minute, 5 AM level.
    wire [5:0] raw_vec = {raw_am_mode, raw_minute, raw_hour, raw_alarm, raw_timer, raw_mode};
    wire [5:0] dut_v   = {AM_mode, add_minute, add_hour, set_alarm_btn, set_timer_btn, mode_btn};

    int compared = 0;
    int mismatched = 0;

    bit       raw_log [NCH][LOGN];
    int       n_edge;
    bit       m_stable[NCH];
    int       m_rise  [NCH];
    logic [5:0] m_out;

    task automatic set_raw(input logic [5:0] v);
        raw_mode    = v[0];
        raw_timer   = v[1];
        raw_alarm   = v[2];
        raw_hour    = v[3];
        raw_minute  = v[4];
        raw_am_mode = v[5];
    endtask

    function automatic void model_reset();
        n_edge = 0;
        m_out  = '0;
        for (int c = 0; c < NCH; c++) begin
            m_stable[c] = 1'b0;
            m_rise[c]   = 0;
        end
    endfunction

    // Raw value seen by the debounce logic at edge e: two edges of synchronizer delay.
    function automatic bit sync_at(input int c, input int e);
        return (e >= 3) ? raw_log[c][e-2] : 1'b0;
    endfunction

    function automatic void model_edge();
        logic [4:0] req;
        bit differ;
        int age;
        n_edge++;
        for (int c = 0; c < NCH; c++) raw_log[c][n_edge] = raw_vec[c];
        for (int c = 0; c < NCH; c++) begin
            differ = 1'b1;
            for (int j = 0; j < D; j++)
                if (sync_at(c, n_edge - j) == m_stable[c]) differ = 1'b0;
            if (differ) begin
                m_stable[c] = !m_stable[c];
                if (m_stable[c]) m_rise[c] = n_edge;
            end
        end
        req = '0;
        for (int c = 0; c < 5; c++) begin
            if (m_stable[c]) begin
                age = n_edge - m_rise[c];
                if (age == 0) req[c] = 1'b1;
                else if (AR && c >= 3 && age >= RD && ((age - RD) % RP) == 0) req[c] = 1'b1;
            end
        end
        m_out = '0;
        for (int c = 0; c < 5; c++) begin
            if (req[c]) begin
                m_out[c] = 1'b1;
                break;
            end
        end
        m_out[5] = m_stable[5];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_raw(6'b111111);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (dut_v !== 6'b0) begin
                mismatched++;
                $display("FAIL reset_hold cycle %0d: got %b want 000000", i, dut_v);
            end
        end
        set_raw(6'b0);
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            compared++;
            if (dut_v !== 6'b0 || m_out !== 6'b0) begin
                mismatched++;
                $display("FAIL reset_idle edge %0d: got %b model %b want 000000", e, dut_v, m_out);
            end
        end
    endtask

    task automatic test_single_press();
        int pulses = 0;
        set_raw(6'b0);
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            set_raw({5'b0, (e >= 5 && e < 15)});
            tick();
            pulses += $countones(dut_v[4:0]);
            compared++;
            if (mode_btn !== (e == 10)) begin
                mismatched++;
                $display("FAIL press_mode edge %0d: got %b want %b", e, mode_btn, (e == 10));
            end
            compared++;
            if (dut_v !== m_out) begin
                mismatched++;
                $display("FAIL press_model edge %0d: got %b want %b", e, dut_v, m_out);
            end
        end
        compared++;
        if (pulses !== 1) begin
            mismatched++;
            $display("FAIL press_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_glitch();
        set_raw(6'b0);
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            set_raw({1'b0, (e >= 5 && e < 8), 4'b0});
            tick();
            compared++;
            if (dut_v !== 6'b0 || m_out !== 6'b0) begin
                mismatched++;
                $display("FAIL glitch edge %0d: got %b model %b want 000000", e, dut_v, m_out);
            end
        end
    endtask

    task automatic test_autorepeat();
        bit exp_h;
        set_raw(6'b0);
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            set_raw({2'b0, (e >= 3 && e <= 32), 3'b0});
            tick();
            // Stable rise at edge 8, stable fall at edge 38.
            exp_h = (e == 8) || (AR && e >= 16 && e < 38 && ((e - 16) % 2) == 0);
            compared++;
            if (add_hour !== exp_h) begin
                mismatched++;
                $display("FAIL repeat_hour edge %0d: got %b want %b", e, add_hour, exp_h);
            end
            compared++;
            if (dut_v !== m_out) begin
                mismatched++;
                $display("FAIL repeat_model edge %0d: got %b want %b", e, dut_v, m_out);
            end
        end
    endtask

    task automatic test_collision();
        set_raw(6'b0);
        do_reset();
        for (int e = 1; e <= 25; e++) begin
            set_raw({1'b0, (e >= 3 && e <= 8), 3'b0, (e >= 3 && e <= 8)});
            tick();
            compared++;
            if (mode_btn !== (e == 8) || add_minute !== 1'b0) begin
                mismatched++;
                $display("FAIL collision edge %0d: got mode=%b minute=%b want mode=%b minute=0",
                         e, mode_btn, add_minute, (e == 8));
            end
            compared++;
            if (dut_v !== m_out) begin
                mismatched++;
                $display("FAIL collision_model edge %0d: got %b want %b", e, dut_v, m_out);
            end
        end
    endtask

    task automatic test_am_mode();
        set_raw(6'b0);
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            set_raw({(e <= 20), 5'b0});
            tick();
            compared++;
            if (dut_v !== {(e >= 6 && e < 26), 5'b0}) begin
                mismatched++;
                $display("FAIL am_follow edge %0d: got %b want AM=%b no pulses", e, dut_v, (e >= 6 && e < 26));
            end
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        // Reset while a timer press is still being debounced.
        set_raw(6'b0);
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            set_raw(6'b000010);
            tick();
        end
        set_raw(6'b0);
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            tick();
            compared++;
            if (dut_v !== 6'b0) begin
                mismatched++;
                $display("FAIL abort_debounce edge %0d: got %b want 000000", e, dut_v);
            end
        end
        // Reset during the repeat phase of a held hour button, then keep holding.
        set_raw(6'b001000);
        do_reset();
        for (int e = 1; e <= 20; e++) tick();
        compared++;
        if (add_hour !== AR) begin
            mismatched++;
            $display("FAIL pre_abort_hour: got %b want %b", add_hour, AR);
        end
        reset = 1'b1;
        #1;
        compared++;
        if (dut_v !== 6'b0) begin
            mismatched++;
            $display("FAIL abort_repeat_async: got %b want 000000", dut_v);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= D + 6; e++) begin
            tick();
            pulses += $countones(dut_v[4:0]);
            compared++;
            if (add_hour !== (e == D + 2) || dut_v !== m_out) begin
                mismatched++;
                $display("FAIL held_release edge %0d: got %b model %b want hour=%b", e, dut_v, m_out, (e == D + 2));
            end
        end
        compared++;
        if (pulses !== 1) begin
            mismatched++;
            $display("FAIL held_release_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_random();
        int hold[NCH];
        logic [5:0] v = '0;
        set_raw(6'b0);
        do_reset();
        for (int c = 0; c < NCH; c++) hold[c] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    v[c] = ~v[c];
                    hold[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 40))
                                                          : int'($urandom_range(1, 8));
                end else begin
                    hold[c]--;
                end
            end
            set_raw(v);
            tick();
            compared++;
            if (dut_v !== m_out) begin
                mismatched++;
                $display("FAIL random cycle %0d: got %b want %b", n, dut_v, m_out);
            end
            compared++;
            if ($countones(dut_v[4:0]) > 1) begin
                mismatched++;
                $display("FAIL random_onehot cycle %0d: got %b want at most one pulse", n, dut_v[4:0]);
            end
            if (n == 700) begin
                reset = 1'b1;
                #1;
                compared++;
                if (dut_v !== 6'b0) begin
                    mismatched++;
                    $display("FAIL random_reset: got %b want 000000", dut_v);
                end
                model_reset();
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_glitch();
        test_autorepeat();
        test_collision();
        test_am_mode();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
